// File: rtl/ram_sync_clr.sv
// ram_sync_clr: byte-masked synchronous RAM with optional full-memory clear sequencer (enabled by macro RAM_CLEAR_EN)
module ram_sync_clr #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   Addr,
  input  logic                Write_En,
  input  logic [DATA_W/8-1:0] Byte_En,
  input  logic [DATA_W-1:0]   D,
  input  logic                Clear_Req,
  output logic [DATA_W-1:0]   O,
  output logic                Busy
);
  localparam int NB = DATA_W / 8;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [NB-1:0]     be;
`ifdef RAM_CLEAR_EN
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;
  logic [0:0]        state;
  logic [ADDR_W-1:0] ptr;
  assign Busy = state == CLEAR;
  // sequencer: reset or Clear_Req starts a sweep from address 0; it ends after the top address
  always_ff @(posedge clk)
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (Busy) begin
      ptr <= ptr + 1'b1;
      if (ptr == '1) state <= IDLE;
    end else if (Clear_Req) begin
      state <= CLEAR;
      ptr   <= '0;
    end
  // the sweep owns the write port while busy; a write coinciding with Clear_Req is dropped
  always_comb begin
    we = !rst && (Busy || (Write_En && !Clear_Req));
    wa = Busy ? ptr : Addr;
    wd = Busy ? '0 : D;
    be = Busy ? '1 : Byte_En;
  end
  // read port: zero whenever Busy is high or about to go high
  always_ff @(posedge clk)
    O <= (rst || Busy || Clear_Req) ? '0 : mem[Addr];
`else
  logic unused_clear;
  assign unused_clear = Clear_Req;
  assign Busy = 1'b0;
  // user writes go straight to the write port
  always_comb begin
    we = !rst && Write_En;
    wa = Addr;
    wd = D;
    be = Byte_En;
  end
  // read port: reset only clears the output register
  always_ff @(posedge clk)
    O <= rst ? '0 : mem[Addr];
`endif
  // byte-masked write port shared by user writes and the clear sweep; reads see the old word
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[wa][8*i +: 8] <= wd[8*i +: 8];
endmodule

// File: tb/tb_ram_sync_clr.sv
// tb_ram_sync_clr: directed bench with a word-level reference model checked every cycle
module tb_ram_sync_clr;
`ifdef RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  Addr = '0;
  logic        Write_En = 1'b0;
  logic [1:0]  Byte_En = '0;
  logic [15:0] D = '0;
  logic        Clear_Req = 1'b0;
  logic [15:0] O;
  logic        Busy;
  int          checks = 0;
  int          errors = 0;
  // reference model: plain word array, per-word "known" flag, and cycles of clear remaining
  logic [15:0] m [256];
  bit          kv [256];
  int          left = 0;
  bit          armed = 1'b0;
  bit          ok = 1'b0;
  logic [15:0] exp_o = '0;
  int          n;

  ram_sync_clr #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .Write_En(Write_En), .Byte_En(Byte_En),
    .D(D), .Clear_Req(Clear_Req), .O(O), .Busy(Busy)
  );

  always #5 clk = ~clk;

  initial for (int k = 0; k < 256; k++) kv[k] = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      left  = CLR ? 256 : 0;
      exp_o = '0;
      ok    = 1'b1;
    end else if (left > 0) begin
      m[256-left]  = '0;
      kv[256-left] = 1'b1;
      left  = left - 1;
      exp_o = '0;
      ok    = 1'b1;
    end else if (CLR && Clear_Req) begin
      left  = 256;
      exp_o = '0;
      ok    = 1'b1;
    end else begin
      exp_o = m[Addr];
      ok    = kv[Addr];
      if (Write_En) begin
        if (Byte_En[0]) m[Addr][7:0]  = D[7:0];
        if (Byte_En[1]) m[Addr][15:8] = D[15:8];
        if (Byte_En == 2'b11) kv[Addr] = 1'b1;
      end
    end
  end

  always @(negedge clk)
    if (armed) begin
      checks++;
      if (Busy !== (left > 0)) begin
        errors++;
        $display("FAIL cycle_busy t=%0t got=%b want=%b", $time, Busy, left > 0);
      end
      if (ok) begin
        checks++;
        if (O !== exp_o) begin
          errors++;
          $display("FAIL cycle_o t=%0t got=%h want=%h", $time, O, exp_o);
        end
      end
    end

  task automatic drive(input logic r, input logic [7:0] a, input logic w, input logic [1:0] b,
                       input logic [15:0] d, input logic c);
    @(negedge clk);
    rst = r; Addr = a; Write_En = w; Byte_En = b; D = d; Clear_Req = c;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (Busy === 1'b1 && cnt < 400) begin
      cnt++;
      drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    end
  endtask

  initial begin
    drive(1, 8'h00, 0, 2'b00, 16'h0000, 0);
`ifdef RAM_CLEAR_EN
    drive(0, 8'h00, 1, 2'b11, 16'hFFFF, 1);
    chk("rst_busy", {31'd0, Busy}, 32'd1);
    chk("rst_o", {16'd0, O}, 32'd0);
    count_busy(n);
    chk("rst_busy_len", n, 256);
    drive(0, 8'h12, 0, 2'b00, 16'h0000, 0);
    drive(0, 8'hF0, 0, 2'b00, 16'h0000, 0);
    chk("rd_12_cleared", {16'd0, O}, 32'h0000);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    chk("rd_f0_cleared", {16'd0, O}, 32'h0000);
    drive(0, 8'h12, 1, 2'b11, 16'h1234, 0);
    drive(0, 8'h12, 0, 2'b00, 16'h0000, 0);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    chk("wr_full_12", {16'd0, O}, 32'h1234);
    drive(0, 8'h12, 1, 2'b01, 16'hABCD, 0);
    drive(0, 8'h12, 0, 2'b00, 16'h0000, 0);
    chk("rdw_old_12", {16'd0, O}, 32'h1234);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    chk("wr_low_byte_12", {16'd0, O}, 32'h12CD);
    drive(0, 8'h12, 1, 2'b00, 16'h9999, 0);
    drive(0, 8'h12, 0, 2'b00, 16'h0000, 0);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    chk("be_zero_no_write", {16'd0, O}, 32'h12CD);
    drive(0, 8'h34, 1, 2'b11, 16'h7777, 1);
    drive(0, 8'h34, 1, 2'b11, 16'h3456, 1);
    chk("cr_busy", {31'd0, Busy}, 32'd1);
    chk("cr_o_zero", {16'd0, O}, 32'd0);
    count_busy(n);
    chk("cr_busy_len", n, 256);
    drive(0, 8'h34, 0, 2'b00, 16'h0000, 0);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    chk("busy_write_ignored", {16'd0, O}, 32'h0000);
    drive(0, 8'h12, 1, 2'b11, 16'h1111, 0);
    drive(0, 8'h56, 1, 2'b11, 16'h5678, 1);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    count_busy(n);
    chk("cr_we_busy_len", n, 256);
    drive(0, 8'h12, 0, 2'b00, 16'h0000, 0);
    drive(0, 8'h56, 0, 2'b00, 16'h0000, 0);
    chk("cr_we_12", {16'd0, O}, 32'h0000);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    chk("cr_we_56", {16'd0, O}, 32'h0000);
    drive(0, 8'hAA, 1, 2'b11, 16'hAAAA, 0);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 1);
    for (int k = 0; k < 100; k++) drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    drive(1, 8'h00, 0, 2'b00, 16'h0000, 0);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    count_busy(n);
    chk("mid_rst_len", n, 256);
    drive(0, 8'hAA, 0, 2'b00, 16'h0000, 0);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    chk("mid_rst_aa", {16'd0, O}, 32'h0000);
`else
    drive(0, 8'hDE, 1, 2'b11, 16'hDEF0, 1);
    chk("nc_rst_o", {16'd0, O}, 32'd0);
    chk("nc_busy0", {31'd0, Busy}, 32'd0);
    drive(0, 8'hDE, 0, 2'b00, 16'h0000, 1);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    chk("nc_rd_de", {16'd0, O}, 32'hDEF0);
    chk("nc_busy_cr", {31'd0, Busy}, 32'd0);
    drive(0, 8'h12, 1, 2'b11, 16'h1234, 0);
    drive(0, 8'h12, 1, 2'b01, 16'hABCD, 0);
    drive(0, 8'h12, 0, 2'b00, 16'h0000, 0);
    chk("nc_rdw_old", {16'd0, O}, 32'h1234);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    chk("nc_low_byte", {16'd0, O}, 32'h12CD);
    drive(0, 8'h12, 1, 2'b10, 16'h5500, 0);
    drive(0, 8'h12, 0, 2'b00, 16'h0000, 0);
    drive(0, 8'hDE, 0, 2'b00, 16'h0000, 0);
    chk("nc_high_byte", {16'd0, O}, 32'h55CD);
    drive(1, 8'hDE, 1, 2'b11, 16'h0BAD, 0);
    drive(0, 8'hDE, 0, 2'b00, 16'h0000, 0);
    chk("nc_rst_o2", {16'd0, O}, 32'd0);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    chk("nc_rst_blocks_write", {16'd0, O}, 32'hDEF0);
    for (int k = 0; k < 20; k++) drive(0, 8'(k), 1, 2'b11, 16'(k * 257), k[0]);
    for (int k = 0; k < 20; k++) drive(0, 8'(k), 0, 2'b00, 16'h0000, 1);
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    chk("nc_busy_end", {31'd0, Busy}, 32'd0);
`endif
    drive(0, 8'h00, 0, 2'b00, 16'h0000, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_sync_clr.md
RAM_SYNC_CLR -- requirements
Module: ram_sync_clr

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 8: address width; depth is 2**ADDR_W words.
REQ-002 The block SHALL take parameter DATA_W, default 16: word width; legal values are multiples of 8 only.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port Addr, input, ADDR_W bits: read/write word address.
REQ-006 The block SHALL have port Write_En, input, 1 bit: write request.
REQ-007 The block SHALL have port Byte_En, input, DATA_W/8 bits: per-byte write mask; bit i qualifies D[8i+7:8i].
REQ-008 The block SHALL have port D, input, DATA_W bits: write data.
REQ-009 The block SHALL have port Clear_Req, input, 1 bit: start a full-memory clear.
REQ-010 The block SHALL have port O, output, DATA_W bits: registered read data.
REQ-011 The block SHALL have port Busy, output, 1 bit: high while the clear sequencer runs.

Function
REQ-012 Storage SHALL be 2**ADDR_W words of DATA_W bits.
REQ-013 Reads SHALL be synchronous with 1-cycle latency: Addr sampled at edge N gives O valid after edge N, held until edge N+1.
REQ-014 Read-during-write to the same address SHALL return the old (pre-write) word on O.
REQ-015 A write SHALL occur at a rising edge when Write_En=1 and Busy=0; only bytes with Byte_En[i]=1 are updated; Byte_En=0 writes nothing.
REQ-016 The sequencer SHALL have two states: IDLE and CLEAR.
REQ-017 IDLE->CLEAR SHALL occur on Clear_Req=1; the clear pointer loads 0 and Busy=1 from the next cycle.
REQ-018 In CLEAR the sequencer SHALL write all-zero to the pointer address each cycle and increment the pointer.
REQ-019 CLEAR->IDLE SHALL occur after the write of address 2**ADDR_W-1; the pointer wraps to 0 and Busy=0 from the next cycle; CLEAR lasts exactly 2**ADDR_W cycles.
REQ-020 While Busy=1, Write_En, Byte_En, D and Clear_Req SHALL be ignored, and O SHALL read 0.
REQ-021 Clear_Req and Write_En asserted together in IDLE SHALL result in the clear starting and the write being dropped.
REQ-022 Addr SHALL cover the full range with no out-of-range condition; the pointer SHALL be ADDR_W bits wide with natural wrap.

Reset
REQ-023 With rst=1 at an edge, state SHALL go to CLEAR, pointer to 0, O to 0 and Busy to 1; rst outranks all other inputs.
REQ-024 rst asserted mid-clear SHALL restart the clear from address 0, for a full 2**ADDR_W cycles after rst falls.
REQ-025 rst SHALL not need to be held more than one cycle.

Configuration
REQ-026 With macro RAM_CLEAR_EN defined, the clear sequencer and the behaviour in REQ-016 to REQ-024 SHALL be compiled in.
REQ-027 Without RAM_CLEAR_EN: no sequencer, Busy tied 0, Clear_Req ignored, reset clears only O to 0, memory contents after reset undefined, and writes accepted from the first edge after rst falls.

Verification (ADDR_W=8, DATA_W=16, RAM_CLEAR_EN defined unless stated)
REQ-028 Bench SHALL check: rst for 1 cycle -> Busy=1 for exactly 256 cycles, then 0; reads of 8'h12 and 8'hF0 return 16'h0000.
REQ-029 Bench SHALL check: after clear, write Addr=8'h12, D=16'h1234, Byte_En=2'b11, then read 8'h12 -> O=16'h1234 one cycle after Addr is presented.
REQ-030 Bench SHALL check: write Addr=8'h12, D=16'hABCD, Byte_En=2'b01 -> read 8'h12 gives 16'h12CD; a simultaneous read of 8'h12 during the write cycle gives 16'h1234.
REQ-031 Bench SHALL check: write 8'h34=16'h3456 during Busy=1 -> after clear, read 8'h34 gives 16'h0000.
REQ-032 Bench SHALL check: Clear_Req and Write_En (8'h56, 16'h5678) asserted together -> 256 Busy cycles; afterwards 8'h12 and 8'h56 both read 16'h0000.
REQ-033 Bench SHALL check, with RAM_CLEAR_EN undefined: Busy stays 0 throughout; writing 8'hDE=16'hDEF0 on the first cycle after rst reads back 16'hDEF0.
